// File: rtl/synth_pkg.sv
// Shared sequencer constants: sizes, playback state encoding, note one-hot codes.
package synth_pkg;
  localparam int NUM_STEPS = 8;
  localparam int STEP_W    = 3;
  localparam int KEY_W     = 12;
  localparam int TICK_W    = 26;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} play_state_t;

  localparam logic [KEY_W-1:0] NOTE_C  = 12'h800;
  localparam logic [KEY_W-1:0] NOTE_CS = 12'h400;
  localparam logic [KEY_W-1:0] NOTE_D  = 12'h200;
  localparam logic [KEY_W-1:0] NOTE_DS = 12'h100;
  localparam logic [KEY_W-1:0] NOTE_E  = 12'h080;
  localparam logic [KEY_W-1:0] NOTE_F  = 12'h040;
  localparam logic [KEY_W-1:0] NOTE_FS = 12'h020;
  localparam logic [KEY_W-1:0] NOTE_G  = 12'h010;
  localparam logic [KEY_W-1:0] NOTE_GS = 12'h008;
  localparam logic [KEY_W-1:0] NOTE_A  = 12'h004;
  localparam logic [KEY_W-1:0] NOTE_AS = 12'h002;
  localparam logic [KEY_W-1:0] NOTE_B  = 12'h001;
  localparam logic [KEY_W-1:0] REST    = '0;

  // A step shorter than 2 clocks is stretched to 2.
  function automatic logic [TICK_W-1:0] eff_ticks(input logic [TICK_W-1:0] t);
    return (t < TICK_W'(2)) ? TICK_W'(2) : t;
  endfunction
endpackage

// File: rtl/step_seq_player_if.sv
// Recording/playback control bundle between the sequencer FSM and the step player.
interface step_seq_player_if;
  import synth_pkg::*;
  logic              wr_en;
  logic [STEP_W-1:0] wr_step;
  logic [KEY_W-1:0]  wr_keys;
  logic              play;
  logic [TICK_W-1:0] step_ticks;
  logic [TICK_W-1:0] gate_ticks;
  logic [KEY_W-1:0]  keys_out;
  logic [STEP_W-1:0] step_out;
  logic              step_pulse;
  logic              playing;

  modport master (output wr_en, wr_step, wr_keys, play, step_ticks, gate_ticks,
                  input  keys_out, step_out, step_pulse, playing);
  modport slave  (input  wr_en, wr_step, wr_keys, play, step_ticks, gate_ticks,
                  output keys_out, step_out, step_pulse, playing);
endinterface

// File: rtl/step_note_mem.sv
// Step note storage: flop array, sync write/clear, combinational read with write-first bypass.
module step_note_mem #(
  parameter int NUM_STEPS = 8,
  parameter int STEP_W    = 3,
  parameter int KEY_W     = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_step,
  input  logic [KEY_W-1:0]  wr_keys,
  input  logic [STEP_W-1:0] rd_step,
  output logic [KEY_W-1:0]  rd_keys
);
  logic [NUM_STEPS-1:0][KEY_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (!reset_n) mem <= '0;
    else if (wr_en) mem[wr_step] <= wr_keys;
  end

  // Same-edge write to the step being read wins over stored data.
  assign rd_keys = (wr_en && wr_step == rd_step) ? wr_keys : mem[rd_step];
endmodule

// File: rtl/step_seq_player.sv
// Step sequencer playback: walks the note memory one step per tempo period while play is high.
module step_seq_player
  import synth_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  step_seq_player_if.slave bus
);
  play_state_t       state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [KEY_W-1:0]  keys_q, keys_nxt, rd_keys;
  logic              pulse_q, pulse_nxt, last;

  step_note_mem #(.NUM_STEPS(NUM_STEPS), .STEP_W(STEP_W), .KEY_W(KEY_W)) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.wr_en),
    .wr_step (bus.wr_step),
    .wr_keys (bus.wr_keys),
    .rd_step (step_nxt),
    .rd_keys (rd_keys)
  );

  // Step length compared live so a shortened step_ticks takes effect at once.
  assign last = tick >= (eff_ticks(bus.step_ticks) - TICK_W'(1));

  always_comb begin
    state_nxt = state;
    tick_nxt  = '0;
    step_nxt  = '0;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: if (bus.play) begin
        state_nxt = PLAY;
        pulse_nxt = 1'b1;
      end
      PLAY: begin
        if (!bus.play) state_nxt = IDLE;
        else if (last) begin
          step_nxt  = step + STEP_W'(1);
          pulse_nxt = 1'b1;
        end else begin
          tick_nxt = tick + TICK_W'(1);
          step_nxt = step;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    keys_nxt = '0;
    if (state_nxt == PLAY && tick_nxt < bus.gate_ticks) keys_nxt = rd_keys;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      tick    <= '0;
      step    <= '0;
      keys_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      step    <= step_nxt;
      keys_q  <= keys_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign bus.keys_out   = keys_q;
  assign bus.step_out   = step;
  assign bus.step_pulse = pulse_q;
  assign bus.playing    = (state == PLAY);
endmodule

// File: tb/tb_step_seq_player.sv
// Directed bench for step_seq_player: playback, gating, short steps, write-first, stop/restart, reset.
module tb_step_seq_player;
  import synth_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [KEY_W-1:0] notes [NUM_STEPS];

  step_seq_player_if bus ();
  step_seq_player dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [KEY_W-1:0] k, input logic [STEP_W-1:0] s,
                         input logic p, input logic pl);
    chk({tag, ".keys"},    32'(bus.keys_out),   32'(k));
    chk({tag, ".step"},    32'(bus.step_out),   32'(s));
    chk({tag, ".pulse"},   32'(bus.step_pulse), 32'(p));
    chk({tag, ".playing"}, 32'(bus.playing),    32'(pl));
  endtask

  initial begin
    logic [STEP_W-1:0] s;
    notes = '{12'h800, 12'h200, 12'h080, 12'h040, 12'h010, 12'h004, 12'h001, 12'h800};
    reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_step = '0; bus.wr_keys = '0;
    bus.play = 1'b0; bus.step_ticks = TICK_W'(4); bus.gate_ticks = TICK_W'(4);
    repeat (3) @(negedge clk);
    chk_all("reset", '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < NUM_STEPS; i++) begin
      bus.wr_en = 1'b1; bus.wr_step = STEP_W'(i); bus.wr_keys = notes[i];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    chk_all("idle_after_wr", '0, '0, 1'b0, 1'b0);

    // legato playback, 4-clock steps, through the 7->0 wrap
    bus.play = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      s = STEP_W'(c / 4);
      chk_all($sformatf("legato_c%0d", c), notes[s], s, (c % 4) == 0, 1'b1);
    end
    bus.play = 1'b0;
    @(negedge clk);
    chk_all("stop1", '0, '0, 1'b0, 1'b0);

    // half gate
    bus.gate_ticks = TICK_W'(2); bus.play = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s = STEP_W'(c / 4);
      chk_all($sformatf("gate2_c%0d", c), ((c % 4) < 2) ? notes[s] : '0, s, (c % 4) == 0, 1'b1);
    end
    bus.play = 1'b0;
    @(negedge clk);

    // silent gate
    bus.gate_ticks = '0; bus.play = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_all($sformatf("gate0_c%0d", c), '0, STEP_W'(c / 4), (c % 4) == 0, 1'b1);
    end
    bus.play = 1'b0;
    @(negedge clk);

    // step_ticks 0 and 1 stretch to 2 clocks
    bus.gate_ticks = TICK_W'(4);
    for (int t = 0; t < 2; t++) begin
      bus.step_ticks = TICK_W'(t); bus.play = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        s = STEP_W'(c / 2);
        chk_all($sformatf("short%0d_c%0d", t, c), notes[s], s, (c % 2) == 0, 1'b1);
      end
      bus.play = 1'b0;
      @(negedge clk);
    end

    // write-first into step 1 on the edge that loads it
    bus.step_ticks = TICK_W'(4); bus.play = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_all($sformatf("wf_c%0d", c), notes[0], '0, c == 0, 1'b1);
    end
    bus.wr_en = 1'b1; bus.wr_step = STEP_W'(1); bus.wr_keys = 12'h001;
    @(negedge clk);
    bus.wr_en = 1'b0;
    notes[1] = 12'h001;
    chk_all("wf_load", 12'h001, STEP_W'(1), 1'b1, 1'b1);
    @(negedge clk);
    chk_all("wf_hold", 12'h001, STEP_W'(1), 1'b0, 1'b1);

    // run on to step 5, drop play for 3 cycles, restart at step 0
    for (int c = 6; c <= 20; c++) @(negedge clk);
    chk_all("at_step5", notes[5], STEP_W'(5), 1'b1, 1'b1);
    bus.play = 1'b0;
    @(negedge clk);
    chk_all("drop", '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all("dropped", '0, '0, 1'b0, 1'b0);
    bus.play = 1'b1;
    @(negedge clk);
    chk_all("restart", notes[0], '0, 1'b1, 1'b1);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      s = STEP_W'(c / 4);
      chk_all($sformatf("restart_c%0d", c), notes[s], s, (c % 4) == 0, 1'b1);
    end

    // one-cycle reset mid-play clears outputs and memory
    reset_n = 1'b0;
    @(negedge clk);
    chk_all("mid_reset", '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_all($sformatf("post_reset_c%0d", c), '0, STEP_W'(c / 4), (c % 4) == 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_seq_player.md
# step_seq_player

Playback end of the 8-step note sequencer: holds the recorded step memory (written by the sequencer `control` FSM's write/step_number outputs) and, while play is asserted, reads it back one step per tempo period, driving a 12-bit one-hot key vector into `datapath` in place of live keyboard keys. Sits between the recording FSM and the `datapath`/`freq_adapter` path in `final_top`; a top-level mux selects live `keys` vs. `keys_out`.

## Interface
- `NUM_STEPS`, 8, sequence length; power of two.
- `STEP_W`, 3, log2(`NUM_STEPS`).
- `KEY_W`, 12, key vector width (one bit per semitone, bit 11 = C … bit 0 = B).
- `TICK_W`, 26, width of tempo/gate counters (50 MHz clock).

- `clk`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write `wr_keys` into step `wr_step` this cycle.
- `wr_step`  in  `STEP_W`  write address.
- `wr_keys`  in  `KEY_W`  note to store; 0 = rest.
- `play`  in  1  level; high = run, low = stop.
- `step_ticks`  in  `TICK_W`  clocks per step; values < 2 treated as 2.
- `gate_ticks`  in  `TICK_W`  clocks per step the note sounds; ≥ `step_ticks` = legato, 0 = silent.
- `keys_out`  out  `KEY_W`  registered note for current step, 0 outside gate.
- `step_out`  out  `STEP_W`  registered index of current step.
- `step_pulse`  out  1  one-cycle pulse on the first cycle of each step.
- `playing`  out  1  high in PLAY state.

## Operation
- States: IDLE, PLAY. IDLE→PLAY when `play`=1; PLAY→IDLE when `play`=0. No other transitions.
- Memory: `NUM_STEPS`×`KEY_W` flops, combinational read, write on `wr_en` in any state. Data stored verbatim (non-one-hot values pass through; downstream treats them as silence).
- Write-first: write to the step being loaded into `keys_out` on the same edge uses `wr_keys`.
- Tick counter `tick` runs 0…eff_ticks−1, eff_ticks = max(`step_ticks`,2). On the edge where `tick` ≥ eff_ticks−1: `tick`←0, `step`←(`step`+1) mod `NUM_STEPS` (7→0 wrap), `step_pulse`←1.
- `keys_out` ← mem[next step] if next `tick` < `gate_ticks`, else 0.
- `step_ticks` changed mid-step: compared live; if current `tick` already ≥ new eff_ticks−1, advance on next edge.
- Reset (any state, any time): state IDLE, memory cleared to 0, `tick`=0, `step`=0, all outputs 0.
- IDLE: `keys_out`=0, `step_out`=0, `step_pulse`=0, `playing`=0, `tick` held 0.

## Timing
- All outputs registered; reset value 0 for every output.
- Start latency 1: `play` sampled high at edge N (state IDLE) → after edge N: `playing`=1, `step_out`=0, `tick`=0, `step_pulse`=1, `keys_out`=mem[0] (0 if `gate_ticks`=0).
- Step period exactly eff_ticks clocks; `step_pulse` high 1 cycle per step.
- Stop latency 1: `play` sampled low at edge M → after M all outputs 0; restart always begins at step 0.
- Write visible on `keys_out` at the next edge that loads that step (≤1 cycle if it is the current step within its gate).

## Structure
- Shared package `synth_pkg`: `NUM_STEPS`, `STEP_W`, `KEY_W`, `TICK_W`, state encodings (IDLE=0, PLAY=1), note one-hot constants (NOTE_C=12'h800 … NOTE_B=12'h001), REST=0.
- One sub-module `step_note_mem`: flop array, sync write, sync clear, combinational read with write-first bypass.
- Top of block: FSM, tick/step counters, output registers.

## Test plan
- Reset then write steps 0–7 = C,D,E,F,G,A,B,C (12'h800,12'h200,12'h080,12'h040,12'h010,12'h004,12'h001,12'h800); `step_ticks`=4, `gate_ticks`=4, `play`=1 → `keys_out` sequence in 4-cycle runs, `step_pulse` every 4 cycles, wraps to 12'h800 after step 7.
- `step_ticks`=4, `gate_ticks`=2 → each step: 2 cycles note, 2 cycles 0; `gate_ticks`=0 → `keys_out` stays 0, `step_out` still advances.
- `step_ticks`=0 and 1 → period 2 cycles.
- Mid-play write of 12'h001 to current step on same edge it loads → `keys_out`=12'h001 immediately (write-first).
- Drop `play` at step 5, raise 3 cycles later → restart at step 0, 1-cycle latency both ways.
- `reset_n`=0 mid-play for 1 cycle → all outputs 0, memory reads 0 on subsequent play.
